// File: rtl/mem_port_if.sv
// Signal bundle between mem_port_arbiter, its three requesters and the shared RAM.
// slave is the arbiter's view; master is the view of the surrounding core, loader and RAM.
interface mem_port_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [31:0]           inst_addr;
  logic                  inst_req;
  logic                  inst_ack;
  logic [31:0]           inst_q;

  logic [31:0]           data_addr;
  logic [31:0]           data_wdata;
  logic [3:0]            data_mask;
  logic                  data_wren;
  logic                  data_req;
  logic                  data_ack;
  logic [31:0]           data_q;

  logic                  load_active;
  logic                  load_wr;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [31:0]           load_data;
  logic                  load_overflow;

  logic                  bus_err;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [3:0]            ram_be;
  logic                  ram_we;
  logic [31:0]           ram_q;

  modport slave (
    input  inst_addr, inst_req,
    output inst_ack, inst_q,
    input  data_addr, data_wdata, data_mask, data_wren, data_req,
    output data_ack, data_q,
    input  load_active, load_wr, load_addr, load_data,
    output load_overflow,
    output bus_err,
    output ram_addr, ram_wdata, ram_be, ram_we,
    input  ram_q
  );

  modport master (
    output inst_addr, inst_req,
    input  inst_ack, inst_q,
    output data_addr, data_wdata, data_mask, data_wren, data_req,
    input  data_ack, data_q,
    output load_active, load_wr, load_addr, load_data,
    input  load_overflow,
    input  bus_err,
    input  ram_addr, ram_wdata, ram_be, ram_we,
    output ram_q
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for kronos fetch, kronos load/store and the program loader.
// Define ARB_ROUND_ROBIN_EN to alternate inst/data on ties; otherwise data always wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  mem_port_if.slave bus
);

  localparam int unsigned HI_SHIFT  = ADDR_WIDTH + 2;
  localparam logic [1:0]  LAST_WAIT = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LWRITE,
    S_CWRITE,
    S_CREAD,
    S_ACK
  } state_t;

  state_t                state, state_n;
  logic [1:0]            wait_cnt, wait_cnt_n;
  logic                  gnt_data, gnt_data_n;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [31:0]           buf_data;
  logic                  overflow;

  logic                  inst_ack_r, inst_ack_n;
  logic [31:0]           inst_q_r, inst_q_n;
  logic                  data_ack_r, data_ack_n;
  logic [31:0]           data_q_r, data_q_n;
  logic                  bus_err_r, bus_err_n;
  logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_n;
  logic [31:0]           ram_wdata_r, ram_wdata_n;
  logic [3:0]            ram_be_r, ram_be_n;
  logic                  ram_we_r, ram_we_n;

`ifdef ARB_ROUND_ROBIN_EN
  logic                  rr_data, rr_data_n;
`endif

  logic                  core_req;
  logic                  pick_data;
  logic [31:0]           sel_addr;
  logic                  out_of_range;
  logic                  buf_free;
  logic                  unused_addr_bits;

  // Core arbitration: closed while a download runs; the loader buffer is checked first in IDLE.
  always_comb begin
    core_req = !bus.load_active && (bus.inst_req || bus.data_req);
`ifdef ARB_ROUND_ROBIN_EN
    pick_data = bus.data_req && (!bus.inst_req || rr_data);
`else
    pick_data = bus.data_req;
`endif
    sel_addr     = pick_data ? bus.data_addr : bus.inst_addr;
    out_of_range = (sel_addr >> HI_SHIFT) != 32'd0;
  end

  assign unused_addr_bits = ^sel_addr[1:0];

  // The slot frees at the end of LWRITE, so a strobe landing in that cycle still fits.
  assign buf_free = !buf_valid || (state == S_LWRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      overflow  <= 1'b0;
    end else if (bus.load_wr) begin
      if (buf_free) begin
        buf_valid <= 1'b1;
        buf_addr  <= bus.load_addr;
        buf_data  <= bus.load_data;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (state == S_LWRITE) begin
      buf_valid <= 1'b0;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    gnt_data_n  = gnt_data;
    inst_ack_n  = 1'b0;
    data_ack_n  = 1'b0;
    bus_err_n   = 1'b0;
    ram_we_n    = 1'b0;
    inst_q_n    = inst_q_r;
    data_q_n    = data_q_r;
    ram_addr_n  = ram_addr_r;
    ram_wdata_n = ram_wdata_r;
    ram_be_n    = ram_be_r;
`ifdef ARB_ROUND_ROBIN_EN
    rr_data_n   = rr_data;
`endif

    case (state)
      S_IDLE: begin
        if (buf_valid) begin
          state_n     = S_LWRITE;
          ram_we_n    = 1'b1;
          ram_addr_n  = buf_addr;
          ram_wdata_n = buf_data;
          ram_be_n    = 4'hF;
        end else if (core_req) begin
          gnt_data_n = pick_data;
`ifdef ARB_ROUND_ROBIN_EN
          rr_data_n  = !pick_data;
`endif
          if (out_of_range) begin
            // No RAM cycle: answer straight away with zero data and an error flag.
            state_n   = S_ACK;
            bus_err_n = 1'b1;
            if (pick_data) begin
              data_ack_n = 1'b1;
              data_q_n   = '0;
            end else begin
              inst_ack_n = 1'b1;
              inst_q_n   = '0;
            end
          end else if (pick_data && bus.data_wren) begin
            state_n     = S_CWRITE;
            ram_we_n    = 1'b1;
            ram_addr_n  = sel_addr[ADDR_WIDTH+1:2];
            ram_wdata_n = bus.data_wdata;
            ram_be_n    = bus.data_mask;
          end else begin
            state_n    = S_CREAD;
            wait_cnt_n = '0;
            ram_addr_n = sel_addr[ADDR_WIDTH+1:2];
          end
        end
      end

      S_LWRITE: state_n = S_IDLE;

      S_CWRITE: begin
        state_n    = S_ACK;
        data_ack_n = 1'b1;
      end

      // ram_q becomes valid READ_LATENCY cycles after the address; latch it on the last wait cycle.
      S_CREAD: begin
        if (wait_cnt == LAST_WAIT) begin
          state_n = S_ACK;
          if (gnt_data) begin
            data_ack_n = 1'b1;
            data_q_n   = bus.ram_q;
          end else begin
            inst_ack_n = 1'b1;
            inst_q_n   = bus.ram_q;
          end
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end

      S_ACK: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      gnt_data    <= 1'b0;
      inst_ack_r  <= 1'b0;
      inst_q_r    <= '0;
      data_ack_r  <= 1'b0;
      data_q_r    <= '0;
      bus_err_r   <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_be_r    <= '0;
      ram_we_r    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data     <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      gnt_data    <= gnt_data_n;
      inst_ack_r  <= inst_ack_n;
      inst_q_r    <= inst_q_n;
      data_ack_r  <= data_ack_n;
      data_q_r    <= data_q_n;
      bus_err_r   <= bus_err_n;
      ram_addr_r  <= ram_addr_n;
      ram_wdata_r <= ram_wdata_n;
      ram_be_r    <= ram_be_n;
      ram_we_r    <= ram_we_n;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data     <= rr_data_n;
`endif
    end
  end

  assign bus.inst_ack      = inst_ack_r;
  assign bus.inst_q        = inst_q_r;
  assign bus.data_ack      = data_ack_r;
  assign bus.data_q        = data_q_r;
  assign bus.bus_err       = bus_err_r;
  assign bus.load_overflow = overflow;
  assign bus.ram_addr      = ram_addr_r;
  assign bus.ram_wdata     = ram_wdata_r;
  assign bus.ram_be        = ram_be_r;
  assign bus.ram_we        = ram_we_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a word-level memory model.
// Build with ARB_ROUND_ROBIN_EN defined on both files to check the alternating arbitration variant.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned AW     = 15;
  localparam int unsigned RL     = 1;
  localparam int unsigned NWORDS = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_if #(.ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM with READ_LATENCY-deep output pipe, a backdoor preload port and activity counters
  logic [31:0]   ram     [0:(1<<AW)-1];
  logic [31:0]   rd_pipe [0:RL-1];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  int            we_cycles  = 0;
  int            err_pulses = 0;
  int            inst_acks  = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [3:0]    last_we_be   = '0;

  always @(posedge clk) begin
    rd_pipe[0] <= ram[bus.ram_addr];
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
    if (pl_en) ram[pl_addr] <= pl_data;
    if (bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_be[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      we_cycles    <= we_cycles + 1;
      last_we_addr <= bus.ram_addr;
      last_we_be   <= bus.ram_be;
    end
    if (bus.bus_err)  err_pulses <= err_pulses + 1;
    if (bus.inst_ack) inst_acks  <= inst_acks + 1;
  end

  assign bus.ram_q = rd_pipe[RL-1];

  // Reference: expected contents of the low RAM words
  logic [31:0] model [0:NWORDS-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One core transaction from an idle bus; inputs are scrambled after grant to prove they were captured.
  task automatic do_req(input bit is_data, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mk, input bit wr,
                        output logic [31:0] q, output int lat, output logic err);
    logic seen;
    @(negedge clk);
    if (is_data) begin
      bus.data_addr  = addr;
      bus.data_wdata = wd;
      bus.data_mask  = mk;
      bus.data_wren  = wr;
      bus.data_req   = 1'b1;
    end else begin
      bus.inst_addr  = addr;
      bus.inst_req   = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = is_data ? bus.data_ack : bus.inst_ack;
      if (!seen) begin
        if (is_data) begin
          bus.data_addr  = $urandom;
          bus.data_wdata = $urandom;
          bus.data_mask  = 4'($urandom);
          bus.data_wren  = 1'($urandom_range(0, 1));
        end else begin
          bus.inst_addr  = $urandom;
        end
      end
    end
    check("ack_seen", 32'(seen), 32'd1);
    q   = is_data ? bus.data_q : bus.inst_q;
    err = bus.bus_err;
    if (is_data) bus.data_req = 1'b0;
    else         bus.inst_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(is_data ? bus.data_ack : bus.inst_ack), 32'd0);
    check("err_one_cycle", 32'(bus.bus_err), 32'd0);
  endtask

  logic [31:0] q, addr, wd, d;
  logic [3:0]  mk;
  logic        err, seen, is_data, wr, oob;
  int          lat, we0, err0, ack0, n, cyc, w;
  logic [3:0]  got_d, exp_d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inst_addr = '0;  bus.inst_req = 1'b0;
    bus.data_addr = '0;  bus.data_wdata = '0; bus.data_mask = '0;
    bus.data_wren = 1'b0; bus.data_req = 1'b0;
    bus.load_active = 1'b0; bus.load_wr = 1'b0; bus.load_addr = '0; bus.load_data = '0;

    for (int i = 0; i < int'(NWORDS); i++) begin
      model[i] = (i == 4) ? 32'hDEADBEEF : $urandom;
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = AW'(i);
      pl_data = model[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);

    check("rst_inst_ack", 32'(bus.inst_ack), 32'd0);
    check("rst_data_ack", 32'(bus.data_ack), 32'd0);
    check("rst_inst_q",   bus.inst_q, 32'd0);
    check("rst_data_q",   bus.data_q, 32'd0);
    check("rst_bus_err",  32'(bus.bus_err), 32'd0);
    check("rst_ram_we",   32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_be",   32'(bus.ram_be), 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_overflow", 32'(bus.load_overflow), 32'd0);
    reset = 1'b0;

    // fetch of word 4
    we0 = we_cycles;
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, q, lat, err);
    check("fetch_latency", 32'(lat), 32'(RL + 2));
    check("fetch_q", q, 32'hDEADBEEF);
    check("fetch_no_we", 32'(we_cycles - we0), 32'd0);

    // byte-masked store followed by a load of the same word
    we0 = we_cycles;
    do_req(1'b1, 32'h8, 32'h11223344, 4'b0110, 1'b1, q, lat, err);
    model[2] = merge(model[2], 32'h11223344, 4'b0110);
    check("store_latency", 32'(lat), 32'd2);
    check("store_we_cycles", 32'(we_cycles - we0), 32'd1);
    check("store_ram_addr", 32'(last_we_addr), 32'd2);
    check("store_ram_be", 32'(last_we_be), 32'b0110);
    do_req(1'b1, 32'h8, 32'd0, 4'h0, 1'b0, q, lat, err);
    check("merge_q", q, model[2]);
    check("load_latency", 32'(lat), 32'(RL + 2));

    // out-of-range load
    we0 = we_cycles; err0 = err_pulses;
    do_req(1'b1, 32'hFFFF_0000, 32'd0, 4'h0, 1'b0, q, lat, err);
    check("oob_latency", 32'(lat), 32'd1);
    check("oob_q", q, 32'd0);
    check("oob_err", 32'(err), 32'd1);
    check("oob_err_pulses", 32'(err_pulses - err0), 32'd1);
    check("oob_no_we", 32'(we_cycles - we0), 32'd0);

    // download of 8 words while a fetch waits
    @(negedge clk);
    bus.load_active = 1'b1;
    @(negedge clk);
    bus.inst_addr = 32'h0;
    bus.inst_req  = 1'b1;
    ack0 = inst_acks;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i] = d;
      bus.load_wr = 1'b1; bus.load_addr = AW'(i); bus.load_data = d;
      @(negedge clk);
      bus.load_wr = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("dl_overflow", 32'(bus.load_overflow), 32'd0);
    check("dl_no_inst_ack", 32'(inst_acks - ack0), 32'd0);
    for (int i = 0; i < 8; i++) check("dl_word", ram[i], model[i]);
    bus.load_active = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      seen = bus.inst_ack;
    end
    check("dl_inst_ack", 32'(seen), 32'd1);
    check("dl_inst_q", bus.inst_q, model[0]);
    bus.inst_req = 1'b0;
    @(negedge clk);

    // two back-to-back loader strobes while a read is in flight
    @(negedge clk);
    bus.data_addr = 32'h30; bus.data_wren = 1'b0; bus.data_req = 1'b1;
    @(negedge clk);
    bus.load_active = 1'b1;
    d = $urandom;
    model[20] = d;
    bus.load_wr = 1'b1; bus.load_addr = AW'(20); bus.load_data = d;
    @(negedge clk);
    bus.load_wr = 1'b1; bus.load_addr = AW'(21); bus.load_data = ~model[21];
    @(negedge clk);
    bus.load_wr = 1'b0;
    seen = bus.data_ack; cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      seen = bus.data_ack;
    end
    check("ovf_data_ack", 32'(seen), 32'd1);
    check("ovf_data_q", bus.data_q, model[12]);
    bus.data_req = 1'b0;
    repeat (4) @(negedge clk);
    check("ovf_first_written", ram[20], model[20]);
    check("ovf_second_dropped", ram[21], model[21]);
    check("ovf_flag", 32'(bus.load_overflow), 32'd1);
    bus.load_active = 1'b0;
    repeat (4) @(negedge clk);
    check("ovf_sticky", 32'(bus.load_overflow), 32'd1);

    // reset in the middle of a read
    bus.data_addr = 32'h30; bus.data_wren = 1'b0; bus.data_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_no_ack", 32'(bus.data_ack), 32'd0);
    check("midrst_no_we", 32'(bus.ram_we), 32'd0);
    reset = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk);
    check("midrst_no_late_ack", 32'(bus.data_ack), 32'd0);
    check("midrst_overflow_clr", 32'(bus.load_overflow), 32'd0);
    @(negedge clk);

    // tie between inst and data, both held across four grants
    bus.data_addr = 32'h20; bus.data_wren = 1'b0; bus.inst_addr = 32'h24;
    bus.data_req = 1'b1; bus.inst_req = 1'b1;
    n = 0; cyc = 0; got_d = '0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (bus.data_ack) begin
        check("arb_data_q", bus.data_q, model[8]);
        got_d[n] = 1'b1; n++;
      end else if (bus.inst_ack) begin
        check("arb_inst_q", bus.inst_q, model[9]);
        got_d[n] = 1'b0; n++;
      end
    end
    check("arb_grant_count", 32'(n), 32'd4);
    bus.data_req = 1'b0;
    if (got_d[3]) begin
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 40) begin
        @(negedge clk); cyc++;
        seen = bus.inst_ack;
      end
      check("arb_inst_drain", 32'(seen), 32'd1);
    end
    bus.inst_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) check("arb_grant", 32'(got_d[i]), 32'(exp_d[i]));
    @(negedge clk);

    // random traffic
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        w = $urandom_range(0, NWORDS - 1);
        d = $urandom;
        model[w] = d;
        @(negedge clk);
        bus.load_wr = 1'b1; bus.load_addr = AW'(w); bus.load_data = d;
        @(negedge clk);
        bus.load_wr = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        is_data = 1'($urandom_range(0, 1));
        wr      = is_data && ($urandom_range(0, 1) == 1);
        oob     = ($urandom_range(0, 7) == 0);
        w       = $urandom_range(0, NWORDS - 1);
        addr    = oob ? ((32'd1 << (AW + 2)) | $urandom) : ((32'(w) << 2) | 32'($urandom_range(0, 3)));
        wd      = $urandom;
        mk      = 4'($urandom);
        do_req(is_data, addr, wd, mk, wr, q, lat, err);
        check("rnd_latency", 32'(lat), oob ? 32'd1 : (wr ? 32'd2 : 32'(RL + 2)));
        check("rnd_bus_err", 32'(err), 32'(oob));
        if (!wr) check("rnd_q", q, oob ? 32'd0 : model[w]);
        if (wr && !oob) model[w] = merge(model[w], wd, mk);
      end
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < int'(NWORDS); i++) check("final_ram", ram[i], model[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
